// File: rtl/instr_encoder.sv
// Instruction encoder: turns op/register/immediate requests into 8-bit words
// and writes them sequentially into an instruction memory during a program load.
module instr_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              valid_i,
  input  logic [3:0]        op_i,
  input  logic [2:0]        rd_i,
  input  logic [2:0]        rs_i,
  input  logic [4:0]        imm_i,
  output logic              ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [7:0]        imem_data_o,
  output logic [ADDR_W:0]   count_o,
  output logic              done_o,
  output logic [1:0]        err_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_e;

  localparam logic [7:0]        HALT_WORD    = 8'h88;
  localparam logic [1:0]        ERR_NONE     = 2'b00;
  localparam logic [1:0]        ERR_ILLEGAL  = 2'b01;
  localparam logic [1:0]        ERR_OVERFLOW = 2'b10;
  localparam logic [ADDR_W-1:0] LAST_ADDR    = '1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [7:0]          word_q, word_d;
  logic [1:0]          err_q, err_d;

  logic [7:0]          enc_word;
  logic                enc_legal;

  always_comb begin
    enc_word  = 8'h00;
    enc_legal = 1'b1;
    case (op_i)
      4'd0:    enc_word = {2'b00, rd_i, rs_i};
      4'd1:    enc_word = {2'b01, rd_i, rs_i};
      4'd2:    enc_word = {3'b110, imm_i};
      4'd3:    enc_word = {5'b11100, rs_i};
      4'd4:    enc_word = {5'b11101, rs_i};
      4'd5:    enc_word = {5'b11110, rs_i};
      4'd6:    enc_word = {5'b11111, rs_i};
      4'd7:    enc_word = 8'b1000_0000;
      4'd8:    enc_word = HALT_WORD;
      4'd9:    enc_word = {5'b10010, rs_i};
      4'd10:   enc_word = {5'b10011, rs_i};
      4'd11:   enc_word = {5'b10100, rs_i};
      4'd12:   enc_word = {5'b10101, rs_i};
      4'd13:   enc_word = {5'b10110, rs_i};
      default: enc_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    word_d  = word_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start_i) begin
          state_d = S_ACCEPT;
          addr_d  = '0;
          count_d = '0;
          err_d   = ERR_NONE;
        end
      end
      S_ACCEPT: begin
        if (valid_i) begin
          if (enc_legal) begin
            word_d  = enc_word;
            state_d = S_WRITE;
          end else begin
            err_d   = ERR_ILLEGAL;
            state_d = S_ERROR;
          end
        end
      end
      S_WRITE: begin
        // Increment wraps naturally to 0 after the last slot.
        addr_d  = addr_q + 1'b1;
        count_d = count_q + 1'b1;
        if (word_q == HALT_WORD) begin
          state_d = S_DONE;
        end else if (addr_q == LAST_ADDR) begin
          err_d   = ERR_OVERFLOW;
          state_d = S_ERROR;
        end else begin
          state_d = S_ACCEPT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      word_q  <= 8'h00;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      word_q  <= word_d;
      err_q   <= err_d;
    end
  end

  // Strobes decode from the state register only, so valid_i never reaches them.
  assign ready_o     = (state_q == S_ACCEPT);
  assign imem_we_o   = (state_q == S_WRITE);
  assign done_o      = (state_q == S_DONE);
  assign imem_addr_o = imem_we_o ? addr_q : '0;
  assign imem_data_o = imem_we_o ? word_q : 8'h00;
  assign count_o     = count_q;
  assign err_o       = err_q;

endmodule
